// File: rtl/zspram_pingpong_ctrl_if.sv
// Bus bundle for zspram_pingpong_ctrl: capture input, SPRAM pair
// port and the drain stream toward the DDR writer.
interface zspram_pingpong_ctrl_if #(
  parameter int AW = 14
);

  logic          iWr_Valid;
  logic [15:0]   iWr_Data;

  logic          oSP_Which;
  logic [AW-1:0] oSP_WrAddr;
  logic [15:0]   oSP_WrData;
  logic          oSP_WrEn;
  logic [AW-1:0] oSP_RdAddr;
  logic          oSP_RdEn;
  logic [15:0]   iSP_RdData;

  logic [15:0]   oOut_Data;
  logic          oOut_Valid;
  logic          iOut_Ready;
  logic          oOut_Last;

  logic          oOverflow;
  logic          oSwap;

  modport master (
    input  iWr_Valid,
    input  iWr_Data,
    output oSP_Which,
    output oSP_WrAddr,
    output oSP_WrData,
    output oSP_WrEn,
    output oSP_RdAddr,
    output oSP_RdEn,
    input  iSP_RdData,
    output oOut_Data,
    output oOut_Valid,
    input  iOut_Ready,
    output oOut_Last,
    output oOverflow,
    output oSwap
  );

  modport slave (
    output iWr_Valid,
    output iWr_Data,
    input  oSP_Which,
    input  oSP_WrAddr,
    input  oSP_WrData,
    input  oSP_WrEn,
    input  oSP_RdAddr,
    input  oSP_RdEn,
    output iSP_RdData,
    input  oOut_Data,
    input  oOut_Valid,
    output iOut_Ready,
    input  oOut_Last,
    input  oOverflow,
    input  oSwap
  );

endinterface

// File: rtl/zspram_pingpong_ctrl.sv
// zspram_pingpong_ctrl: ping-pong capture into an SPRAM pair,
// with a two-entry skid buffer draining the idle bank.
module zspram_pingpong_ctrl #(
  parameter int DEPTH = 16384,
  parameter int AW    = 14
) (
  input  logic                   iClk,
  input  logic                   iRst,
  zspram_pingpong_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } rd_state_e;

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic          which_q;
  logic          which_d;
  logic [AW-1:0] wr_cnt_q;
  logic [AW-1:0] wr_cnt_d;
  logic          wr_full_q;
  logic          wr_full_d;
  logic          ovf_q;
  logic          ovf_d;

  rd_state_e     st_q;
  rd_state_e     st_d;
  logic [AW-1:0] rd_cnt_q;
  logic [AW-1:0] rd_cnt_d;
  logic          inf_q;
  logic          inf_d;
  logic          inf_last_q;
  logic          inf_last_d;

  logic [1:0]    sk_cnt_q;
  logic [1:0]    sk_cnt_d;
  logic [16:0]   sk0_q;
  logic [16:0]   sk0_d;
  logic [16:0]   sk1_q;
  logic [16:0]   sk1_d;

  logic          swap;
  logic          wr_go;
  logic          wr_drop;
  logic          rd_go;
  logic          room;
  logic          push;
  logic          pop;
  logic [2:0]    occ;
  logic [AW-1:0] rd_addr;
  logic [16:0]   rd_word;

  // The swap cycle already reads the freshly filled bank, so the
  // bank select flips combinationally in that cycle.
  assign swap    = wr_full_q & (st_q == IDLE);
  assign wr_go   = bus.iWr_Valid & ~wr_full_q;
  assign wr_drop = bus.iWr_Valid & wr_full_q;

  assign push    = inf_q;
  assign pop     = (sk_cnt_q != 2'd0) & bus.iOut_Ready;
  assign occ     = 3'(sk_cnt_q) + 3'(inf_q);
  assign room    = pop ? (occ <= 3'd2) : (occ <= 3'd1);
  assign rd_go   = (swap | (st_q == DRAIN)) & room;
  assign rd_addr = swap ? '0 : rd_cnt_q;
  assign rd_word = {inf_last_q, bus.iSP_RdData};

  assign bus.oSP_Which  = which_q ^ swap;
  assign bus.oSP_WrEn   = wr_go;
  assign bus.oSP_WrAddr = wr_cnt_q;
  assign bus.oSP_WrData = bus.iWr_Data;
  assign bus.oSP_RdEn   = rd_go;
  assign bus.oSP_RdAddr = rd_addr;
  assign bus.oOut_Valid = (sk_cnt_q != 2'd0);
  assign bus.oOut_Data  = sk0_q[15:0];
  assign bus.oOut_Last  = sk0_q[16] & (sk_cnt_q != 2'd0);
  assign bus.oOverflow  = ovf_q;
  assign bus.oSwap      = swap;

  // Write side: fill the write bank, then refuse words until swap.
  always_comb begin
    wr_cnt_d  = wr_cnt_q;
    wr_full_d = wr_full_q;
    ovf_d     = ovf_q | wr_drop;
    if (wr_go) begin
      if (wr_cnt_q == LAST) begin
        wr_cnt_d  = '0;
        wr_full_d = 1'b1;
      end else begin
        wr_cnt_d  = wr_cnt_q + 1'b1;
      end
    end
    if (swap) begin
      wr_full_d = 1'b0;
    end
  end

  // Read FSM: swap into DRAIN, issue every address, then FLUSH.
  always_comb begin
    st_d       = st_q;
    rd_cnt_d   = rd_cnt_q;
    which_d    = which_q;
    inf_d      = rd_go;
    inf_last_d = rd_go & (rd_addr == LAST);
    unique case (st_q)
      IDLE: begin
        if (swap) begin
          which_d  = ~which_q;
          st_d     = DRAIN;
          rd_cnt_d = rd_go ? AW'(1) : '0;
        end
      end
      DRAIN: begin
        if (rd_go) begin
          if (rd_cnt_q == LAST) begin
            rd_cnt_d = '0;
            st_d     = FLUSH;
          end else begin
            rd_cnt_d = rd_cnt_q + 1'b1;
          end
        end
      end
      FLUSH: begin
        if ((sk_cnt_q == 2'd0) && !inf_q) begin
          st_d = IDLE;
        end
      end
      default: begin
        st_d = IDLE;
      end
    endcase
  end

  // Skid buffer: entry 0 is the head presented on the stream.
  always_comb begin
    sk_cnt_d = sk_cnt_q;
    sk0_d    = sk0_q;
    sk1_d    = sk1_q;
    case ({push, pop})
      2'b11: begin
        if (sk_cnt_q == 2'd1) begin
          sk0_d = rd_word;
        end else begin
          sk0_d = sk1_q;
          sk1_d = rd_word;
        end
      end
      2'b01: begin
        sk0_d    = sk1_q;
        sk_cnt_d = sk_cnt_q - 2'd1;
      end
      2'b10: begin
        if (sk_cnt_q == 2'd0) begin
          sk0_d = rd_word;
        end else begin
          sk1_d = rd_word;
        end
        sk_cnt_d = sk_cnt_q + 2'd1;
      end
      default: begin
      end
    endcase
  end

  // State registers; reset also discards any read in flight.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      which_q    <= 1'b0;
      wr_cnt_q   <= '0;
      wr_full_q  <= 1'b0;
      ovf_q      <= 1'b0;
      st_q       <= IDLE;
      rd_cnt_q   <= '0;
      inf_q      <= 1'b0;
      inf_last_q <= 1'b0;
      sk_cnt_q   <= 2'd0;
      sk0_q      <= '0;
      sk1_q      <= '0;
    end else begin
      which_q    <= which_d;
      wr_cnt_q   <= wr_cnt_d;
      wr_full_q  <= wr_full_d;
      ovf_q      <= ovf_d;
      st_q       <= st_d;
      rd_cnt_q   <= rd_cnt_d;
      inf_q      <= inf_d;
      inf_last_q <= inf_last_d;
      sk_cnt_q   <= sk_cnt_d;
      sk0_q      <= sk0_d;
      sk1_q      <= sk1_d;
    end
  end

endmodule

// File: tb/tb_zspram_pingpong_ctrl.sv
// tb_zspram_pingpong_ctrl: directed and randomized checks of the
// ping-pong controller against an SPRAM model and a word scoreboard.
module tb_zspram_pingpong_ctrl;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  zspram_pingpong_ctrl_if #(.AW(AW)) bus ();

  zspram_pingpong_ctrl #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) dut (
    .iClk(clk),
    .iRst(rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural SPRAM pair: write bank = Which, read bank = ~Which.
  logic [15:0] mem [2][DEPTH];
  always @(posedge clk) begin
    if (bus.oSP_WrEn) mem[bus.oSP_Which][bus.oSP_WrAddr] <= bus.oSP_WrData;
    if (bus.oSP_RdEn) bus.iSP_RdData <= mem[~bus.oSP_Which][bus.oSP_RdAddr];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  logic [16:0] expq[$];
  int          issued;
  int          accepted;
  int          swaps;
  logic        m_which;
  logic        stall;
  logic [16:0] held;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.iWr_Valid = 1'b0;
    bus.iWr_Data  = '0;
    bus.iOut_Ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic sb_clear();
    expq.delete();
    issued   = 0;
    accepted = 0;
    swaps    = 0;
    m_which  = 1'b0;
    stall    = 1'b0;
    held     = '0;
  endtask

  // One cycle of scoreboard checking; inputs already applied.
  task automatic rcyc();
    logic [16:0] e;
    @(negedge clk);
    if (bus.oSwap) begin
      m_which = ~m_which;
      swaps++;
      chk("rnd_which", bus.oSP_Which, m_which);
    end
    if (bus.iWr_Valid) chk("rnd_wren", bus.oSP_WrEn, 1);
    if (stall) begin
      chk("rnd_hold_v", bus.oOut_Valid, 1);
      chk("rnd_hold_d", {bus.oOut_Last, bus.oOut_Data}, held);
    end
    if (bus.oSP_RdEn) issued++;
    if (bus.oOut_Valid && bus.iOut_Ready) begin
      chk("rnd_not_extra", expq.size() != 0, 1);
      if (expq.size() != 0) begin
        e = expq.pop_front();
        chk("rnd_word", {bus.oOut_Last, bus.oOut_Data}, e);
      end
      accepted++;
    end
    chk("rnd_outstanding_le2", (issued - accepted) <= 2, 1);
    stall = bus.oOut_Valid & ~bus.iOut_Ready;
    held  = {bus.oOut_Last, bus.oOut_Data};
    @(posedge clk);
    #1;
  endtask

  // Fill one bank back-to-back with ready high and check exact timing.
  task automatic seq034(input logic [15:0] base, input logic exp_w);
    bus.iOut_Ready = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      bus.iWr_Valid = 1'b1;
      bus.iWr_Data  = base + 16'(k);
      @(negedge clk);
      chk("s34_wren", bus.oSP_WrEn, 1);
      chk("s34_wraddr", bus.oSP_WrAddr, k);
      chk("s34_wrdata", bus.oSP_WrData, base + 16'(k));
      chk("s34_noswap", bus.oSwap, 0);
      @(posedge clk);
      #1;
    end
    bus.iWr_Valid = 1'b0;
    @(negedge clk);
    chk("s34_swap", bus.oSwap, 1);
    chk("s34_which", bus.oSP_Which, exp_w);
    chk("s34_rden", bus.oSP_RdEn, 1);
    chk("s34_rdaddr", bus.oSP_RdAddr, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("s34_swap_pulse", bus.oSwap, 0);
    chk("s34_latency_v", bus.oOut_Valid, 0);
    for (int k = 0; k < DEPTH; k++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("s34_out_v", bus.oOut_Valid, 1);
      chk("s34_out_d", bus.oOut_Data, base + 16'(k));
      chk("s34_out_last", bus.oOut_Last, k == DEPTH - 1);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("s34_end_v", bus.oOut_Valid, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int got;
    int sw;
    int n;
    int sw0;
    int sent;
    logic tog;

    rst            = 1'b1;
    bus.iWr_Valid  = 1'b0;
    bus.iWr_Data   = '0;
    bus.iOut_Ready = 1'b0;
    sb_clear();

    do_reset();
    @(negedge clk);
    chk("rst_which", bus.oSP_Which, 0);
    chk("rst_valid", bus.oOut_Valid, 0);
    chk("rst_last", bus.oOut_Last, 0);
    chk("rst_ovf", bus.oOverflow, 0);
    chk("rst_swap", bus.oSwap, 0);
    chk("rst_wren", bus.oSP_WrEn, 0);
    chk("rst_rden", bus.oSP_RdEn, 0);
    @(posedge clk);
    #1;

    seq034(16'd1, 1'b1);

    do_reset();
    bus.iOut_Ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      bus.iWr_Valid = 1'b1;
      bus.iWr_Data  = 16'(k + 1);
      @(negedge clk);
      if (k == 4) begin
        chk("r38_swap_drop", bus.oSP_WrEn, 0);
        chk("r38_swap", bus.oSwap, 1);
      end
      @(posedge clk);
      #1;
    end
    bus.iWr_Valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("r38_ovf_set", bus.oOverflow, 1);
    chk("r38_inflight_v", bus.oOut_Valid, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("r38_valid", bus.oOut_Valid, 0);
    chk("r38_which", bus.oSP_Which, 0);
    chk("r38_ovf_clr", bus.oOverflow, 0);
    chk("r38_swap", bus.oSwap, 0);
    @(posedge clk);
    #1;
    seq034(16'd5, 1'b1);

    do_reset();
    for (int k = 0; k < 13; k++) begin
      bus.iWr_Valid = (k != 4);
      bus.iWr_Data  = 16'((k < 4) ? k + 1 : k);
      @(negedge clk);
      chk("r36_swap", bus.oSwap, k == 4);
      if (k != 4) chk("r36_wren", bus.oSP_WrEn, k < 9);
      @(posedge clk);
      #1;
    end
    bus.iWr_Valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("r36_hold_v", bus.oOut_Valid, 1);
      chk("r36_hold_d", bus.oOut_Data, 1);
      chk("r36_ovf", bus.oOverflow, 1);
      chk("r36_noswap", bus.oSwap, 0);
      @(posedge clk);
      #1;
    end
    bus.iOut_Ready = 1'b1;
    got = 0;
    sw  = 0;
    n   = 0;
    while (got < 8 && n < 60) begin
      @(negedge clk);
      if (bus.oSwap) begin
        sw++;
        chk("r37_swap_after_drain", got, 4);
        chk("r37_which", bus.oSP_Which, 0);
      end
      if (bus.oOut_Valid) begin
        chk("r37_word", {bus.oOut_Last, bus.oOut_Data},
            {(got == 3) || (got == 7), 16'(got + 1)});
        got++;
      end
      @(posedge clk);
      #1;
      n++;
    end
    chk("r37_count", got, 8);
    chk("r37_swaps", sw, 1);
    chk("r37_ovf_sticky", bus.oOverflow, 1);

    do_reset();
    sb_clear();
    tog = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      tog = ~tog;
      bus.iOut_Ready = tog;
      bus.iWr_Valid  = 1'b1;
      bus.iWr_Data   = 16'(k + 1);
      expq.push_back({k == DEPTH - 1, 16'(k + 1)});
      rcyc();
    end
    bus.iWr_Valid = 1'b0;
    n = 0;
    while (expq.size() != 0 && n < 100) begin
      tog = ~tog;
      bus.iOut_Ready = tog;
      rcyc();
      n++;
    end
    chk("r35_drained", expq.size(), 0);
    chk("r35_count", accepted, DEPTH);
    chk("r35_swaps", swaps, 1);

    for (int b = 0; b < 6; b++) begin
      sent = 0;
      n    = 0;
      while (sent < DEPTH && n < 200) begin
        bus.iOut_Ready = 1'($urandom_range(0, 1));
        bus.iWr_Valid  = ($urandom_range(0, 2) != 0);
        bus.iWr_Data   = 16'($urandom);
        if (bus.iWr_Valid) begin
          expq.push_back({sent == DEPTH - 1, bus.iWr_Data});
          sent++;
        end
        rcyc();
        n++;
      end
      bus.iWr_Valid = 1'b0;
      sw0 = swaps;
      n   = 0;
      while (swaps == sw0 && n < 200) begin
        bus.iOut_Ready = 1'($urandom_range(0, 1));
        rcyc();
        n++;
      end
      chk("rnd_swap_seen", swaps != sw0, 1);
    end
    n = 0;
    while (expq.size() != 0 && n < 400) begin
      bus.iOut_Ready = 1'($urandom_range(0, 1));
      rcyc();
      n++;
    end
    chk("rnd_drained", expq.size(), 0);
    chk("rnd_swaps", swaps, 7);
    chk("rnd_ovf", bus.oOverflow, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/zspram_pingpong_ctrl.md
ZSPRAM_PINGPONG_CTRL -- requirements
Module: zspram_pingpong_ctrl

Interface
REQ-001 Parameter DEPTH, default 16384, words per bank per swap (legal range 2..16384).
REQ-002 Parameter AW, default 14, SPRAM address width.
REQ-003 iClk  in  1  single clock; all logic rising-edge.
REQ-004 iRst  in  1  reset, synchronous, active-high.
REQ-005 iWr_Valid  in  1  capture word present this cycle (no backpressure).
REQ-006 iWr_Data  in  16  capture word.
REQ-007 oSP_Which  out  1  bank select to SPRAM pair: bank written = oSP_Which, bank read = ~oSP_Which.
REQ-008 oSP_WrAddr  out  AW  write address.
REQ-009 oSP_WrData  out  16  write data.
REQ-010 oSP_WrEn  out  1  write strobe.
REQ-011 oSP_RdAddr  out  AW  read address.
REQ-012 oSP_RdEn  out  1  read strobe; data returns on iSP_RdData exactly 1 cycle later.
REQ-013 iSP_RdData  in  16  read data from bank ~oSP_Which.
REQ-014 oOut_Data  out  16  drained word to DDR writer.
REQ-015 oOut_Valid  out  1  oOut_Data valid.
REQ-016 iOut_Ready  in  1  DDR writer accepts; transfer = oOut_Valid & iOut_Ready.
REQ-017 oOut_Last  out  1  marks final word of a bank drain (word DEPTH-1).
REQ-018 oOverflow  out  1  sticky; set when a capture word is dropped; cleared only by reset.
REQ-019 oSwap  out  1  one-cycle pulse in the cycle oSP_Which toggles.

Function
REQ-020 Write side: each iWr_Valid while write bank not full SHALL drive oSP_WrEn=1, oSP_WrAddr=wr_cnt, oSP_WrData=iWr_Data combinationally in the same cycle, and increment wr_cnt.
REQ-021 Write at wr_cnt=DEPTH-1 SHALL set wr_full and hold wr_cnt at 0; further iWr_Valid while wr_full SHALL be dropped (oSP_WrEn=0) and set oOverflow.
REQ-022 Read side FSM states: IDLE, DRAIN, FLUSH.
REQ-023 IDLE: no reads; rd_pending=0.
REQ-024 DRAIN: issue oSP_RdEn with oSP_RdAddr=rd_cnt whenever output skid buffer (2 entries) has room counting in-flight reads; rd_cnt increments per issued read; after issuing address DEPTH-1 go to FLUSH.
REQ-025 FLUSH: no new reads; return to IDLE when skid empty and no read in flight (final word accepted).
REQ-026 Returned iSP_RdData SHALL be captured into the skid buffer the cycle after oSP_RdEn; skid SHALL never overflow and SHALL present words in address order.
REQ-027 Word DEPTH-1 SHALL carry oOut_Last=1; all others 0.
REQ-028 Swap condition: wr_full=1 and read FSM in IDLE; in that cycle toggle oSP_Which, pulse oSwap, clear wr_full, set rd_cnt=0, enter DRAIN.
REQ-029 Capture word arriving in the swap cycle SHALL be dropped (oOverflow set) since wr_full is still 1 in that cycle.
REQ-030 First swap after reset drains the first filled bank; no read occurs before the first swap.
REQ-031 iOut_Ready low SHALL stall issuing once skid plus in-flight reaches 2; oOut_Data/oOut_Last SHALL stay stable while oOut_Valid=1 and iOut_Ready=0.
REQ-032 Throughput: with iOut_Ready held 1, one word per cycle after 2-cycle startup latency (swap cycle -> first oOut_Valid 2 cycles later).

Reset
REQ-033 iRst=1 at any time, including mid-fill or mid-drain, SHALL on the next edge set: oSP_Which=0, wr_cnt=0, wr_full=0, rd_cnt=0, FSM=IDLE, skid empty, oOut_Valid=0, oOut_Last=0, oSP_WrEn=0, oSP_RdEn=0, oSwap=0, oOverflow=0; in-flight read data discarded.

Verification
REQ-034 DEPTH=4, 4 consecutive iWr_Valid data 1..4, iOut_Ready=1 -> oSwap at cycle after 4th write, oSP_Which=1, oOut 1,2,3,4 on consecutive cycles, oOut_Last only with 4.
REQ-035 DEPTH=4, iOut_Ready toggled 1/0 every cycle -> words 1..4 delivered in order, none duplicated or lost, no more than 2 reads outstanding.
REQ-036 DEPTH=4, 12 continuous writes with iOut_Ready=0 -> bank 0 fills, swap, bank 1 fills, words 9..12 dropped, oOverflow=1, no second swap until drain finishes.
REQ-037 Bank 1 full during drain of bank 0; drain completes -> swap in cycle after FSM returns to IDLE, oSP_Which back to 0, next drain yields bank 1 data.
REQ-038 iRst asserted mid-drain with one read in flight -> next cycle oOut_Valid=0, oSP_Which=0, oOverflow=0; subsequent 4 writes 5..8 reproduce REQ-034 sequence with 5..8.
